// File: rtl/host_wg_dispatcher.sv
// host_wg_dispatcher: expands one kernel descriptor into per-work-group CTA requests and tracks their retirement
module host_wg_dispatcher #(
  parameter int WG_ID_WIDTH     = 15,
  parameter int WF_COUNT_WIDTH  = 5,
  parameter int WAVE_ITEM_WIDTH = 6,
  parameter int MEM_ADDR_WIDTH  = 32,
  parameter int VGPR_ID_WIDTH   = 10,
  parameter int SGPR_ID_WIDTH   = 10,
  parameter int LDS_ID_WIDTH    = 10,
  parameter int MAX_INFLIGHT    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       knl_valid,
  output logic                       knl_ready,
  input  logic [WG_ID_WIDTH-1:0]     knl_num_wg,
  input  logic [WG_ID_WIDTH-1:0]     knl_wg_id_base,
  input  logic [WF_COUNT_WIDTH-1:0]  knl_num_wf,
  input  logic [WAVE_ITEM_WIDTH-1:0] knl_wf_size,
  input  logic [MEM_ADDR_WIDTH-1:0]  knl_start_pc,
  input  logic [MEM_ADDR_WIDTH-1:0]  knl_csr_knl,
  input  logic [MEM_ADDR_WIDTH-1:0]  knl_pds_base,
  input  logic [MEM_ADDR_WIDTH-1:0]  knl_pds_stride,
  input  logic [VGPR_ID_WIDTH:0]     knl_vgpr_per_wf,
  input  logic [SGPR_ID_WIDTH:0]     knl_sgpr_per_wf,
  input  logic [LDS_ID_WIDTH:0]      knl_lds_size,
  output logic                       host_req_valid_i,
  input  logic                       host_req_ready_o,
  output logic [WG_ID_WIDTH-1:0]     host_req_wg_id_i,
  output logic [WF_COUNT_WIDTH-1:0]  host_req_num_wf_i,
  output logic [WAVE_ITEM_WIDTH-1:0] host_req_wf_size_i,
  output logic [MEM_ADDR_WIDTH-1:0]  host_req_start_pc_i,
  output logic [MEM_ADDR_WIDTH-1:0]  host_req_pds_baseaddr_i,
  output logic [MEM_ADDR_WIDTH-1:0]  host_req_csr_knl_i,
  output logic [VGPR_ID_WIDTH:0]     host_req_vgpr_size_total_i,
  output logic [SGPR_ID_WIDTH:0]     host_req_sgpr_size_total_i,
  output logic [LDS_ID_WIDTH:0]      host_req_lds_size_total_i,
  output logic [VGPR_ID_WIDTH:0]     host_req_vgpr_size_per_wf_i,
  output logic [SGPR_ID_WIDTH:0]     host_req_sgpr_size_per_wf_i,
  input  logic                       host_rsp_valid_o,
  output logic                       host_rsp_ready_i,
  input  logic [WG_ID_WIDTH-1:0]     host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o,
  output logic                       busy,
  output logic                       knl_done,
  output logic                       rsp_err
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int VW = VGPR_ID_WIDTH + 1;
  localparam int SW = SGPR_ID_WIDTH + 1;
  logic [1:0] state;
  logic [WG_ID_WIDTH-1:0] num_wg, base, issued, done, done_nx, rel;
  logic [MEM_ADDR_WIDTH-1:0] stride;
  logic [IW-1:0] inflight;
  logic accept, req_fire, rsp_fire, rsp_bad;
  assign knl_ready = state == IDLE && !rst;
  assign busy = state != IDLE;
  assign host_req_valid_i = state == ISSUE && inflight < IW'(MAX_INFLIGHT);
  assign host_rsp_ready_i = state != IDLE;
  assign accept = knl_valid && knl_ready;
  assign req_fire = host_req_valid_i && host_req_ready_o;
  assign rsp_fire = host_rsp_valid_o && host_rsp_ready_i;
  assign done_nx = done + WG_ID_WIDTH'(rsp_fire);
  // offset from base wraps with the ID space, so any offset at or past issued is bogus
  assign rel = host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o - base;
  assign rsp_bad = rel >= issued;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      num_wg <= '0;
      base <= '0;
      stride <= '0;
      issued <= '0;
      done <= '0;
      inflight <= '0;
      knl_done <= 1'b0;
      rsp_err <= 1'b0;
      host_req_wg_id_i <= '0;
      host_req_num_wf_i <= '0;
      host_req_wf_size_i <= '0;
      host_req_start_pc_i <= '0;
      host_req_pds_baseaddr_i <= '0;
      host_req_csr_knl_i <= '0;
      host_req_vgpr_size_total_i <= '0;
      host_req_sgpr_size_total_i <= '0;
      host_req_lds_size_total_i <= '0;
      host_req_vgpr_size_per_wf_i <= '0;
      host_req_sgpr_size_per_wf_i <= '0;
    end else begin
      knl_done <= 1'b0;
      if (rsp_fire) begin
        done <= done_nx;
        rsp_err <= rsp_err | rsp_bad;
      end
      inflight <= inflight + IW'(req_fire) - IW'(rsp_fire && inflight != '0);
      if (req_fire) begin
        issued <= issued + 1'b1;
        host_req_wg_id_i <= host_req_wg_id_i + 1'b1;
        host_req_pds_baseaddr_i <= host_req_pds_baseaddr_i + stride;
        if (issued + 1'b1 == num_wg) state <= DRAIN;
      end
      // pulse is held one cycle in DRAIN so knl_ready returns only after it
      if (state == DRAIN) begin
        knl_done <= !knl_done && done_nx >= num_wg;
        if (knl_done) state <= IDLE;
      end
      if (accept) begin
        num_wg <= knl_num_wg;
        base <= knl_wg_id_base;
        stride <= knl_pds_stride;
        issued <= '0;
        done <= '0;
        inflight <= '0;
        knl_done <= knl_num_wg == '0;
        state <= knl_num_wg == '0 ? IDLE : ISSUE;
        host_req_wg_id_i <= knl_wg_id_base;
        host_req_num_wf_i <= knl_num_wf;
        host_req_wf_size_i <= knl_wf_size;
        host_req_start_pc_i <= knl_start_pc;
        host_req_pds_baseaddr_i <= knl_pds_base;
        host_req_csr_knl_i <= knl_csr_knl;
        host_req_vgpr_size_total_i <= VW'(knl_vgpr_per_wf * VW'(knl_num_wf));
        host_req_sgpr_size_total_i <= SW'(knl_sgpr_per_wf * SW'(knl_num_wf));
        host_req_lds_size_total_i <= knl_lds_size;
        host_req_vgpr_size_per_wf_i <= knl_vgpr_per_wf;
        host_req_sgpr_size_per_wf_i <= knl_sgpr_per_wf;
      end
    end
  end
endmodule

// File: tb/tb_host_wg_dispatcher.sv
// tb_host_wg_dispatcher: directed kernels with a request scoreboard popped by a negedge monitor
module tb_host_wg_dispatcher;
  localparam int MI = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic knl_valid = 1'b0, knl_ready;
  logic [14:0] knl_num_wg = '0, knl_wg_id_base = '0;
  logic [4:0] knl_num_wf = '0;
  logic [5:0] knl_wf_size = '0;
  logic [31:0] knl_start_pc = '0, knl_csr_knl = '0, knl_pds_base = '0, knl_pds_stride = '0;
  logic [10:0] knl_vgpr_per_wf = '0, knl_sgpr_per_wf = '0, knl_lds_size = '0;
  logic valid, ready = 1'b0;
  logic [14:0] wg_id;
  logic [4:0] num_wf;
  logic [5:0] wf_size;
  logic [31:0] start_pc, pds, csr;
  logic [10:0] vt, st, lds, vpw, spw;
  logic rsp_valid = 1'b0, rsp_ready;
  logic [14:0] rsp_id = '0;
  logic busy, knl_done, rsp_err;
  host_wg_dispatcher #(.MAX_INFLIGHT(MI)) dut (
    .clk(clk), .rst(rst), .knl_valid(knl_valid), .knl_ready(knl_ready),
    .knl_num_wg(knl_num_wg), .knl_wg_id_base(knl_wg_id_base), .knl_num_wf(knl_num_wf),
    .knl_wf_size(knl_wf_size), .knl_start_pc(knl_start_pc), .knl_csr_knl(knl_csr_knl),
    .knl_pds_base(knl_pds_base), .knl_pds_stride(knl_pds_stride), .knl_vgpr_per_wf(knl_vgpr_per_wf),
    .knl_sgpr_per_wf(knl_sgpr_per_wf), .knl_lds_size(knl_lds_size),
    .host_req_valid_i(valid), .host_req_ready_o(ready), .host_req_wg_id_i(wg_id),
    .host_req_num_wf_i(num_wf), .host_req_wf_size_i(wf_size), .host_req_start_pc_i(start_pc),
    .host_req_pds_baseaddr_i(pds), .host_req_csr_knl_i(csr), .host_req_vgpr_size_total_i(vt),
    .host_req_sgpr_size_total_i(st), .host_req_lds_size_total_i(lds),
    .host_req_vgpr_size_per_wf_i(vpw), .host_req_sgpr_size_per_wf_i(spw),
    .host_rsp_valid_o(rsp_valid), .host_rsp_ready_i(rsp_ready),
    .host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o(rsp_id),
    .busy(busy), .knl_done(knl_done), .rsp_err(rsp_err)
  );
  typedef struct packed {
    logic [14:0] id; logic [4:0] nwf; logic [5:0] wfs; logic [31:0] pc, pds, csr;
    logic [10:0] vt, st, lds, vpw, spw;
  } req_t;
  req_t exp_q[$];
  req_t act, prev;
  logic prev_stall = 1'b0;
  int checks = 0, errors = 0, hs_cnt = 0, hs0;
  assign act = {wg_id, num_wf, wf_size, start_pc, pds, csr, vt, st, lds, vpw, spw};
  task automatic chk(input string name, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (rst) prev_stall <= 1'b0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", 256'(valid), 256'(1));
        chk("stall_data", 256'(act), 256'(prev));
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got id %0h want none", wg_id);
        end else chk("req", 256'(act), 256'(exp_q.pop_front()));
        hs_cnt++;
      end
      prev_stall <= valid && !ready;
      prev <= act;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push_kernel(input int n, input logic [10:0] evt, input logic [10:0] est);
    for (int i = 0; i < n; i++) begin
      req_t r;
      r.id = knl_wg_id_base + 15'(i);
      r.nwf = knl_num_wf;
      r.wfs = knl_wf_size;
      r.pc = knl_start_pc;
      r.pds = knl_pds_base + 32'(i) * knl_pds_stride;
      r.csr = knl_csr_knl;
      r.vt = evt;
      r.st = est;
      r.lds = knl_lds_size;
      r.vpw = knl_vgpr_per_wf;
      r.spw = knl_sgpr_per_wf;
      exp_q.push_back(r);
    end
  endtask
  task automatic set_knl(input logic [14:0] n, b, input logic [4:0] nwf, input logic [5:0] wfs,
                         input logic [31:0] pc, c, pb, ps, input logic [10:0] v, s, l);
    knl_num_wg = n; knl_wg_id_base = b; knl_num_wf = nwf; knl_wf_size = wfs;
    knl_start_pc = pc; knl_csr_knl = c; knl_pds_base = pb; knl_pds_stride = ps;
    knl_vgpr_per_wf = v; knl_sgpr_per_wf = s; knl_lds_size = l;
  endtask
  task automatic send_knl;
    int t = 0;
    while (!knl_ready && t < 100) begin
      tick;
      t++;
    end
    chk("knl_ready_wait", 256'(knl_ready), 256'(1));
    hs0 = hs_cnt;
    knl_valid = 1'b1;
    tick;
    knl_valid = 1'b0;
  endtask
  task automatic send_rsp(input logic [14:0] id);
    rsp_valid = 1'b1;
    rsp_id = id;
    chk("rsp_ready", 256'(rsp_ready), 256'(1));
    tick;
    rsp_valid = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) tick;
    chk("rst_knl_ready", 256'(knl_ready), 256'(0));
    chk("rst_valid", 256'(valid), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(knl_done), 256'(0));
    chk("rst_err", 256'(rsp_err), 256'(0));
    chk("rst_rsp_ready", 256'(rsp_ready), 256'(0));
    chk("rst_data", 256'(act), 256'(0));
    rst = 1'b0;
    #1;
    chk("knl_ready_after_rst", 256'(knl_ready), 256'(1));
    // basic burst: four back-to-back requests
    ready = 1'b1;
    set_knl(4, 15'h10, 2, 32, 32'h100, 32'h2000, 32'h9000_0000, 32'h100, 32, 16, 100);
    push_kernel(4, 64, 32);
    send_knl;
    chk("t1_valid_after_accept", 256'(valid), 256'(1));
    repeat (4) tick;
    chk("t1_burst", 256'(hs_cnt - hs0), 256'(4));
    chk("t1_valid_drain", 256'(valid), 256'(0));
    for (int i = 0; i < 4; i++) send_rsp(15'h10 + 15'(i));
    chk("t1_knl_done", 256'(knl_done), 256'(1));
    chk("t1_ready_during_done", 256'(knl_ready), 256'(0));
    tick;
    chk("t1_done_pulse", 256'(knl_done), 256'(0));
    chk("t1_knl_ready", 256'(knl_ready), 256'(1));
    // inflight cap, re-assert after completion, simultaneous issue+completion
    set_knl(7, 15'h200, 3, 16, 32'h400, 32'h3000, 32'h1000, 32'h40, 10, 5, 32);
    push_kernel(7, 30, 15);
    send_knl;
    repeat (6) tick;
    chk("t2_cap_count", 256'(hs_cnt - hs0), 256'(MI));
    chk("t2_cap_valid", 256'(valid), 256'(0));
    send_rsp(15'h200);
    chk("t2_reassert", 256'(valid), 256'(1));
    send_rsp(15'h201);
    chk("t2_same_edge_valid", 256'(valid), 256'(1));
    tick;
    chk("t2_count6", 256'(hs_cnt - hs0), 256'(6));
    chk("t2_cap_again", 256'(valid), 256'(0));
    for (int i = 2; i < 7; i++) send_rsp(15'h200 + 15'(i));
    chk("t2_knl_done", 256'(knl_done), 256'(1));
    chk("t2_count7", 256'(hs_cnt - hs0), 256'(7));
    chk("t2_err", 256'(rsp_err), 256'(0));
    tick;
    chk("t2_knl_ready", 256'(knl_ready), 256'(1));
    // backpressure stability, ID wrap, pds/total truncation
    ready = 1'b0;
    set_knl(3, 15'h7FFF, 31, 63, 32'hDEAD_BEEF, 32'hCAFE_0000, 32'h100, 32'h8000_0000, 2047, 64, 2047);
    push_kernel(3, 2017, 1984);
    send_knl;
    repeat (7) tick;
    chk("t3_no_issue", 256'(hs_cnt - hs0), 256'(0));
    chk("t3_valid_held", 256'(valid), 256'(1));
    ready = 1'b1;
    repeat (3) tick;
    chk("t3_count", 256'(hs_cnt - hs0), 256'(3));
    send_rsp(15'h7FFF);
    send_rsp(15'h0000);
    send_rsp(15'h0001);
    chk("t3_knl_done", 256'(knl_done), 256'(1));
    chk("t3_wrap_no_err", 256'(rsp_err), 256'(0));
    tick;
    // empty kernel
    set_knl(0, 15'h5, 1, 1, 0, 0, 0, 0, 1, 1, 1);
    send_knl;
    chk("t4_knl_done", 256'(knl_done), 256'(1));
    chk("t4_valid", 256'(valid), 256'(0));
    chk("t4_busy", 256'(busy), 256'(0));
    tick;
    chk("t4_pulse", 256'(knl_done), 256'(0));
    chk("t4_no_req", 256'(hs_cnt - hs0), 256'(0));
    // out-of-range completion sets sticky error and still counts
    set_knl(4, 15'h40, 1, 8, 32'h10, 32'h20, 0, 4, 8, 4, 0);
    push_kernel(4, 8, 4);
    send_knl;
    repeat (3) tick;
    ready = 1'b0;
    chk("t5_count3", 256'(hs_cnt - hs0), 256'(3));
    send_rsp(15'h49);
    chk("t5_err_set", 256'(rsp_err), 256'(1));
    send_rsp(15'h40);
    chk("t5_err_sticky", 256'(rsp_err), 256'(1));
    ready = 1'b1;
    tick;
    chk("t5_count4", 256'(hs_cnt - hs0), 256'(4));
    send_rsp(15'h41);
    send_rsp(15'h42);
    chk("t5_knl_done", 256'(knl_done), 256'(1));
    chk("t5_err_kept", 256'(rsp_err), 256'(1));
    tick;
    // reset mid-kernel
    set_knl(4, 15'h100, 2, 4, 32'h80, 32'h90, 32'h5000, 32'h10, 4, 2, 5);
    push_kernel(4, 8, 4);
    send_knl;
    repeat (2) tick;
    rst = 1'b1;
    ready = 1'b0;
    chk("t6_count2", 256'(hs_cnt - hs0), 256'(2));
    exp_q.delete();
    tick;
    chk("t6_valid", 256'(valid), 256'(0));
    chk("t6_busy", 256'(busy), 256'(0));
    chk("t6_err_cleared", 256'(rsp_err), 256'(0));
    chk("t6_rsp_ready", 256'(rsp_ready), 256'(0));
    chk("t6_data", 256'(act), 256'(0));
    rst = 1'b0;
    rsp_valid = 1'b1;
    rsp_id = 15'h100;
    #1;
    chk("t6_stray_refused", 256'(rsp_ready), 256'(0));
    tick;
    rsp_valid = 1'b0;
    chk("t6_idle", 256'(busy), 256'(0));
    ready = 1'b1;
    knl_num_wg = 2;
    push_kernel(2, 8, 4);
    send_knl;
    repeat (2) tick;
    chk("t6_restart_count", 256'(hs_cnt - hs0), 256'(2));
    send_rsp(15'h100);
    send_rsp(15'h101);
    chk("t6_knl_done", 256'(knl_done), 256'(1));
    chk("t6_err", 256'(rsp_err), 256'(0));
    tick;
    chk("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/host_wg_dispatcher.md
# host_wg_dispatcher

Synthesizable kernel-launch sequencer between the host command path and the GPU's CTA scheduler host port. It accepts one kernel descriptor at a time and expands it into `num_wg` consecutive work-group requests on the `host_req_*` valid/ready channel. For each work-group it derives the per-work-group resource totals and the PDS address, caps outstanding work-groups, and collects `host_rsp` completions. It pulses `knl_done` when every work-group of the kernel has retired.

## Interface
Parameters:
- WG_ID_WIDTH, 15: work-group ID width
- WF_COUNT_WIDTH, 5: wavefronts-per-work-group width
- WAVE_ITEM_WIDTH, 6: wavefront size width
- MEM_ADDR_WIDTH, 32: address width
- VGPR_ID_WIDTH, 10; SGPR_ID_WIDTH, 10; LDS_ID_WIDTH, 10: register-file and LDS index widths (size ports are +1 bit)
- MAX_INFLIGHT, 8: maximum outstanding work-groups (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- knl_valid / knl_ready  in / out  1  descriptor handshake
- knl_num_wg  in  WG_ID_WIDTH  work-groups in the kernel
- knl_wg_id_base  in  WG_ID_WIDTH  ID of the first work-group
- knl_num_wf  in  WF_COUNT_WIDTH  wavefronts per work-group
- knl_wf_size  in  WAVE_ITEM_WIDTH  wavefront size
- knl_start_pc, knl_csr_knl, knl_pds_base, knl_pds_stride  in  MEM_ADDR_WIDTH  start PC, metadata base, PDS base, PDS bytes per work-group
- knl_vgpr_per_wf  in  VGPR_ID_WIDTH+1  VGPRs per wavefront
- knl_sgpr_per_wf  in  SGPR_ID_WIDTH+1  SGPRs per wavefront
- knl_lds_size  in  LDS_ID_WIDTH+1  LDS per work-group
- host_req_valid_i / host_req_ready_o  out / in  1  request handshake
- host_req_wg_id_i, host_req_num_wf_i, host_req_wf_size_i, host_req_start_pc_i, host_req_pds_baseaddr_i, host_req_csr_knl_i  out  matching widths
- host_req_vgpr_size_total_i, host_req_sgpr_size_total_i, host_req_lds_size_total_i, host_req_vgpr_size_per_wf_i, host_req_sgpr_size_per_wf_i  out  matching widths
- host_rsp_valid_o / host_rsp_ready_i  in / out  1  completion handshake
- host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o  in  WG_ID_WIDTH  completed work-group ID
- busy  out  1  state ≠ IDLE
- knl_done  out  1  one-cycle pulse when the kernel has fully retired
- rsp_err  out  1  sticky; completion ID outside the issued range

## Operation
- States: IDLE, ISSUE, DRAIN.
- **IDLE**
  - `knl_ready` = 1.
  - On `knl_valid` the block latches all descriptor fields and clears the `issued`, `done` and `inflight` counters.
  - `num_wg` = 0: stays in IDLE and pulses `knl_done` on the next cycle.
  - Otherwise: moves to ISSUE with `wg_idx` = 0.
- **ISSUE**
  - `host_req_valid_i` = (`inflight` < MAX_INFLIGHT), combinational from registered state.
  - Request fields are registered. They are updated only on a handshake or on descriptor accept:
    - wg_id = base + wg_idx
    - pds_baseaddr = pds_base + wg_idx·pds_stride, truncated to MEM_ADDR_WIDTH
    - vgpr_total = num_wf·vgpr_per_wf, truncated to VGPR_ID_WIDTH+1 bits
    - sgpr_total = num_wf·sgpr_per_wf, truncated to SGPR_ID_WIDTH+1 bits
    - lds_total = lds_size
    - per-wf, num_wf, wf_size, start_pc and csr_knl are passed through.
  - On a handshake: `wg_idx`++, `issued`++, `inflight`++. When `issued` reaches `num_wg`, go to DRAIN.
  - wg_id wraps modulo 2^WG_ID_WIDTH.
- **DRAIN**
  - Waits until `done` == `num_wg`.
  - Then pulses `knl_done` for one cycle (registered) and returns to IDLE.
- **Completions**
  - `host_rsp_ready_i` = 1 in ISSUE and DRAIN, 0 in IDLE.
  - Each accepted completion does `done`++ and `inflight`--.
  - If (id − base) mod 2^WG_ID_WIDTH ≥ `issued`, `rsp_err` is set. The completion is still counted.
- **Simultaneous issue and completion:** `inflight` is unchanged; `issued` and `done` both advance.

## Timing
- Reset values:
  - `host_req_valid_i`, `host_rsp_ready_i`, `knl_ready`, `knl_done`, `busy`, `rsp_err` = 0.
  - All `host_req_*` data outputs = 0.
  - `knl_ready` rises in the first cycle after `rst` deasserts.
- Descriptor accepted at edge N → `host_req_valid_i` high in cycle N+1.
- With `host_req_ready_o` held high, one work-group issues per cycle, with no bubbles.
- While valid is high and ready is low, valid and all data outputs hold stable. Valid never drops without a handshake.
- At MAX_INFLIGHT outstanding, valid stays low. It re-asserts the cycle after a completion is accepted.
- Final completion accepted at edge M → `knl_done` high in cycle M+1 → IDLE and `knl_ready` = 1 in cycle M+2.
- `rst` mid-kernel: next cycle is IDLE, all counters are zero and all outputs are at reset values. Late completions are refused until a new descriptor is accepted. `rsp_err` clears only on `rst`.

## Test plan
- num_wg=4, base=0x10, num_wf=2, vgpr=32, sgpr=16, pds_base=0x9000_0000, stride=0x100, ready always 1 → IDs 0x10–0x13 on 4 consecutive cycles; pds 0x9000_0000..0x9000_0300; vgpr_total=64, sgpr_total=32; `knl_done` one cycle after the 4th completion.
- MAX_INFLIGHT=2, num_wg=5, completions withheld → exactly 2 requests issue and valid stays low. Release one completion → the 3rd request is valid the next cycle.
- `host_req_ready_o` low for 7 cycles while valid → all fields stable, no ID skipped or repeated.
- num_wg=0 → `knl_done` pulses the cycle after accept, with no host_req activity.
- Issue handshake and completion on the same edge → `inflight` unchanged. Completion with ID=base+9 while issued=3 → `rsp_err`=1, sticky.
- `rst` asserted after 2 of 4 work-groups issued → outputs zero next cycle; a stray completion is not accepted; a new kernel restarts with `wg_idx`=0.
